// File: rtl/rv32_mod_decode_stage.sv
// rv32_mod_decode_stage
// Halfword alignment buffer plus a single-entry registered decode stage for
// RV32 instructions. Fetch beats of 32 bits are split into halfwords, which are
// reassembled at the buffer head into 16- or 32-bit instructions, decoded, and
// presented on a valid/ready output port.
//
// Build option: define RV32_DECODE_RVC_EN to enable the 16-bit (compressed)
// path. Without it, any head halfword whose low bits are not 2'b11 forms an
// illegal 32-bit instruction, and halfwords fetched from a misaligned pc
// (fetch_pc[1]=1) mark the instruction they belong to as illegal.
module rv32_mod_decode_stage #(
  parameter int BUF_HW   = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_valid,
  output logic                fetch_ready,
  input  logic [31:0]         fetch_data,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  input  logic                flush,
  input  logic                dec_ready,
  output logic                dec_valid,
  output logic [31:0]         dec_instr,
  output logic [PC_WIDTH-1:0] dec_pc,
  output logic [4:0]          dec_rs1,
  output logic [4:0]          dec_rs2,
  output logic [4:0]          dec_rd,
  output logic [5:0]          dec_format,
  output logic [5:0]          dec_func,
  output logic                dec_is_mem,
  output logic                dec_is_compressed,
  output logic                dec_illegal
);

  localparam int PW = (BUF_HW > 1) ? $clog2(BUF_HW) : 1;
  localparam int CW = $clog2(BUF_HW + 1);

  // pointers wrap at BUF_HW, which need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(BUF_HW - 1)) return '0;
    else return p + PW'(1);
  endfunction

  logic [15:0]         hw_mem [BUF_HW];
  logic [BUF_HW-1:0]   hw_mis;
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [PW-1:0]       rd_ptr1, wr_ptr1;
  logic [CW-1:0]       count;
  logic [PC_WIDTH-1:0] head_pc;

  logic                accept;
  logic [CW-1:0]       push_n, pop_n, need, cnt_after_pop;
  logic [15:0]         hw0, hw1;
  logic                head_is_c, head_complete, load;
  logic                head_mis;

  assign rd_ptr1 = ptr_inc(rd_ptr);
  assign wr_ptr1 = ptr_inc(wr_ptr);
  assign hw0     = hw_mem[rd_ptr];
  assign hw1     = hw_mem[rd_ptr1];

`ifdef RV32_DECODE_RVC_EN
  assign head_is_c = (hw0[1:0] != 2'b11);
  assign head_mis  = 1'b0;
`else
  assign head_is_c = 1'b0;
  assign head_mis  = hw_mis[rd_ptr] | hw_mis[rd_ptr1];
`endif

  assign fetch_ready   = !rst && !flush && (count <= CW'(BUF_HW - 2));
  assign accept        = fetch_valid && fetch_ready;
  assign push_n        = accept ? (fetch_pc[1] ? CW'(1) : CW'(2)) : '0;
  assign need          = head_is_c ? CW'(1) : CW'(2);
  assign head_complete = (count >= need);
  assign load          = head_complete && (!dec_valid || dec_ready) && !flush;
  assign pop_n         = load ? need : '0;
  assign cnt_after_pop = count - pop_n;

  // halfword storage; a misaligned beat contributes only its upper halfword
  always_ff @(posedge clk) begin
    if (accept) begin
      if (fetch_pc[1]) begin
        hw_mem[wr_ptr] <= fetch_data[31:16];
        hw_mis[wr_ptr] <= 1'b1;
      end else begin
        hw_mem[wr_ptr]  <= fetch_data[15:0];
        hw_mis[wr_ptr]  <= 1'b0;
        hw_mem[wr_ptr1] <= fetch_data[31:16];
        hw_mis[wr_ptr1] <= 1'b0;
      end
    end
  end

  // occupancy, pointers and head pc; a push into a buffer that is empty after
  // this cycle's pop re-seeds the head pc from the fetch address
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      head_pc <= '0;
    end else begin
      if (accept) wr_ptr <= fetch_pc[1] ? wr_ptr1 : ptr_inc(wr_ptr1);
      if (pop_n == CW'(1))      rd_ptr <= rd_ptr1;
      else if (pop_n == CW'(2)) rd_ptr <= ptr_inc(rd_ptr1);
      count <= cnt_after_pop + push_n;
      if (accept && cnt_after_pop == '0)
        head_pc <= fetch_pc;
      else if (load)
        head_pc <= head_pc + (head_is_c ? PC_WIDTH'(2) : PC_WIDTH'(4));
    end
  end

  logic [31:0] d_instr;
  logic [4:0]  d_rs1, d_rs2, d_rd, opc;
  logic [5:0]  d_fmt, d_func;
  logic [2:0]  f3;
  logic        d_mem, d_ill, d_c;

  // combinational decode of the instruction sitting at the buffer head
  always_comb begin
    d_instr = {hw1, hw0};
    opc     = d_instr[6:2];
    f3      = d_instr[14:12];
    d_fmt   = 6'b000000;
    d_ill   = 1'b0;
    d_c     = 1'b0;
    case (opc)
      5'b00100, 5'b00110, 5'b11001, 5'b00000, 5'b11100: d_fmt = 6'b010000;
      5'b01101, 5'b00101: d_fmt = 6'b000010;
      5'b01100:           d_fmt = 6'b100000;
      5'b11011:           d_fmt = 6'b000011;
      5'b11000:           d_fmt = 6'b001100;
      5'b01000:           d_fmt = 6'b001000;
      5'b00011:           d_fmt = 6'b000000;
      default:            d_ill = 1'b1;
    endcase
    if (d_instr[1:0] != 2'b11 || head_mis) d_ill = 1'b1;
    if (d_ill) d_fmt = 6'b000000;
    d_rs1  = d_fmt[1] ? 5'd0 : d_instr[19:15];
    d_rs2  = (d_fmt[1] || d_fmt[4]) ? 5'd0 : d_instr[24:20];
    d_rd   = d_fmt[3] ? 5'd0 : d_instr[11:7];
    d_func = {opc == 5'b11001, opc == 5'b01101,
              d_instr[30] && (!d_fmt[4] || f3 == 3'b101), f3};
    d_mem  = !d_ill && (opc == 5'b00000 || opc == 5'b01000);
    if (head_is_c) begin
      d_instr = {16'h0000, hw0};
      d_rs1   = 5'd0;
      d_rs2   = 5'd0;
      d_rd    = 5'd0;
      d_fmt   = 6'b000000;
      d_func  = 6'b000000;
      d_mem   = 1'b0;
      d_ill   = 1'b0;
      d_c     = 1'b1;
    end
  end

  // output register: load on free slot, hold under backpressure, drop on flush
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid         <= 1'b0;
      dec_instr         <= '0;
      dec_pc            <= '0;
      dec_rs1           <= '0;
      dec_rs2           <= '0;
      dec_rd            <= '0;
      dec_format        <= '0;
      dec_func          <= '0;
      dec_is_mem        <= 1'b0;
      dec_is_compressed <= 1'b0;
      dec_illegal       <= 1'b0;
    end else if (flush) begin
      dec_valid <= 1'b0;
    end else if (load) begin
      dec_valid         <= 1'b1;
      dec_instr         <= d_instr;
      dec_pc            <= head_pc;
      dec_rs1           <= d_rs1;
      dec_rs2           <= d_rs2;
      dec_rd            <= d_rd;
      dec_format        <= d_fmt;
      dec_func          <= d_func;
      dec_is_mem        <= d_mem;
      dec_is_compressed <= d_c;
      dec_illegal       <= d_ill;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32_mod_decode_stage.sv
// Directed testbench for rv32_mod_decode_stage (default parameters).
// Expected values are hand-decoded from the instruction encodings.
module tb_rv32_mod_decode_stage;

  logic        clk = 1'b0;
  logic        rst, fetch_valid, fetch_ready, flush, dec_ready, dec_valid;
  logic [31:0] fetch_data, fetch_pc, dec_instr, dec_pc;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [5:0]  dec_format, dec_func;
  logic        dec_is_mem, dec_is_compressed, dec_illegal;

  int checks = 0;
  int errors = 0;

  rv32_mod_decode_stage dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .fetch_pc(fetch_pc),
    .flush(flush), .dec_ready(dec_ready), .dec_valid(dec_valid),
    .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_format(dec_format), .dec_func(dec_func),
    .dec_is_mem(dec_is_mem), .dec_is_compressed(dec_is_compressed),
    .dec_illegal(dec_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_data  = d;
    fetch_pc    = pc;
  endtask

  // present one aligned beat, then let it reach the output register
  task automatic send_one(input logic [31:0] d, input logic [31:0] pc);
    beat(d, pc);
    tick();
    fetch_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_data = '0; fetch_pc = '0;
    flush = 1'b0; dec_ready = 1'b0;
    tick(); tick();
    fetch_valid = 1'b1; #1;
    chk("rst_fetch_ready", fetch_ready, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_instr", dec_instr, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_dec_format", dec_format, 0);
    chk("rst_dec_func", dec_func, 0);
    chk("rst_dec_rd", dec_rd, 0);
    chk("rst_dec_illegal", dec_illegal, 0);
    fetch_valid = 1'b0;
    rst = 1'b0; #1;
    chk("post_rst_fetch_ready", fetch_ready, 1);

    // addi x1, x0, 5 at pc 0: one cycle after acceptance -> output valid
    dec_ready = 1'b1;
    beat(32'h00500093, 32'h0);
    tick();
    fetch_valid = 1'b0;
    chk("addi_latency", dec_valid, 0);
    tick();
    chk("addi_valid", dec_valid, 1);
    chk("addi_format", dec_format, 6'b010000);
    chk("addi_rd", dec_rd, 1);
    chk("addi_rs1", dec_rs1, 0);
    chk("addi_rs2", dec_rs2, 0);
    chk("addi_pc", dec_pc, 0);
    chk("addi_instr", dec_instr, 32'h00500093);
    chk("addi_func", dec_func, 0);
    chk("addi_compressed", dec_is_compressed, 0);
    tick();
    chk("addi_drained", dec_valid, 0);

    send_one(32'h40005033, 32'h10);
    chk("sra_func", dec_func, 6'b001101);
    chk("sra_format", dec_format, 6'b100000);
    chk("sra_pc", dec_pc, 32'h10);
    send_one(32'h0000007F, 32'h14);
    chk("ill_illegal", dec_illegal, 1);
    chk("ill_format", dec_format, 0);
    chk("ill_mem", dec_is_mem, 0);
    send_one(32'h00002023, 32'h18);
    chk("sw0_mem", dec_is_mem, 1);
    chk("sw0_rd", dec_rd, 0);
    chk("sw0_format", dec_format, 6'b001000);
    chk("sw0_func", dec_func, 6'b000010);
    send_one(32'h00112223, 32'h1C);
    chk("sw1_rd", dec_rd, 0);
    chk("sw1_rs1", dec_rs1, 2);
    chk("sw1_rs2", dec_rs2, 1);
    chk("sw1_mem", dec_is_mem, 1);
    chk("sw1_illegal", dec_illegal, 0);
    send_one(32'h123452B7, 32'h20);
    chk("lui_format", dec_format, 6'b000010);
    chk("lui_func", dec_func, 6'b010101);
    chk("lui_rs1", dec_rs1, 0);
    chk("lui_rd", dec_rd, 5);
    send_one(32'h000080E7, 32'h24);
    chk("jalr_format", dec_format, 6'b010000);
    chk("jalr_func", dec_func, 6'b100000);
    chk("jalr_rs1", dec_rs1, 1);
    chk("jalr_rd", dec_rd, 1);
    send_one(32'h4010D093, 32'h28);
    chk("srai_func", dec_func, 6'b001101);
    send_one(32'h40000093, 32'h2C);
    chk("addi_b30_func", dec_func, 6'b000000);
    chk("addi_b30_mem", dec_is_mem, 0);
    tick();

    // halfword split across two beats
    beat(32'h00B34501, 32'h0);
    tick();
    beat(32'h00400000, 32'h4);
    tick();
    fetch_valid = 1'b0;
`ifdef RV32_DECODE_RVC_EN
    chk("span_c_instr", dec_instr, 32'h00004501);
    chk("span_c_pc", dec_pc, 0);
    chk("span_c_comp", dec_is_compressed, 1);
    chk("span_c_rd", dec_rd, 0);
    tick();
    chk("span_w_instr", dec_instr, 32'h000000B3);
    chk("span_w_pc", dec_pc, 2);
    chk("span_w_format", dec_format, 6'b100000);
    chk("span_w_rd", dec_rd, 1);
    chk("span_w_comp", dec_is_compressed, 0);
    tick();
    chk("span_c2_instr", dec_instr, 32'h00000040);
    chk("span_c2_pc", dec_pc, 6);
    tick();
    chk("span_empty", dec_valid, 0);
`else
    chk("norvc_instr", dec_instr, 32'h00B34501);
    chk("norvc_pc", dec_pc, 0);
    chk("norvc_illegal", dec_illegal, 1);
    chk("norvc_comp", dec_is_compressed, 0);
    chk("norvc_format", dec_format, 0);
    tick();
    chk("norvc2_instr", dec_instr, 32'h00400000);
    chk("norvc2_pc", dec_pc, 4);
    chk("norvc2_illegal", dec_illegal, 1);
    tick();
    chk("norvc_empty", dec_valid, 0);
`endif

    // misaligned start: only the upper halfword of the first beat is used
    beat(32'h00930000, 32'h302);
    tick();
    beat(32'h00000050, 32'h304);
    tick();
    fetch_valid = 1'b0;
    tick();
    chk("mis_valid", dec_valid, 1);
    chk("mis_instr", dec_instr, 32'h00500093);
    chk("mis_pc", dec_pc, 32'h302);
`ifdef RV32_DECODE_RVC_EN
    chk("mis_illegal", dec_illegal, 0);
`else
    chk("mis_illegal", dec_illegal, 1);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // backpressure with three instructions queued
    dec_ready = 1'b0;
    beat(32'h00500093, 32'h20);
    tick();
    beat(32'h00A00113, 32'h24);
    tick();
    beat(32'h00F00193, 32'h28);
    tick();
    chk("stall_ready_low", fetch_ready, 0);
    beat(32'h01400213, 32'h2C);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", dec_valid, 1);
      chk("stall_instr", dec_instr, 32'h00500093);
      chk("stall_pc", dec_pc, 32'h20);
      chk("stall_ready", fetch_ready, 0);
    end
    dec_ready = 1'b1;
    tick();
    chk("drain_b_instr", dec_instr, 32'h00A00113);
    chk("drain_b_pc", dec_pc, 32'h24);
    chk("drain_ready", fetch_ready, 1);
    tick();
    fetch_valid = 1'b0;
    chk("drain_c_instr", dec_instr, 32'h00F00193);
    chk("drain_c_pc", dec_pc, 32'h28);
    tick();
    chk("drain_d_instr", dec_instr, 32'h01400213);
    chk("drain_d_pc", dec_pc, 32'h2C);
    chk("drain_d_rd", dec_rd, 4);
    tick();
    chk("drain_done", dec_valid, 0);

    // flush with a beat on offer and an instruction on the output
    beat(32'h00500093, 32'h40);
    tick();
    beat(32'h00600113, 32'h44);
    tick();
    chk("pre_flush_valid", dec_valid, 1);
    chk("pre_flush_pc", dec_pc, 32'h40);
    beat(32'h00700193, 32'h48);
    flush = 1'b1; #1;
    chk("flush_ready", fetch_ready, 0);
    tick();
    flush = 1'b0;
    fetch_valid = 1'b0;
    chk("flush_valid", dec_valid, 0);
    tick();
    chk("flush_empty", dec_valid, 0);
    send_one(32'h00900313, 32'h100);
    chk("post_flush_valid", dec_valid, 1);
    chk("post_flush_pc", dec_pc, 32'h100);
    chk("post_flush_instr", dec_instr, 32'h00900313);

    // reset discards a partially assembled instruction
    beat(32'h00930000, 32'h402);
    tick();
    fetch_valid = 1'b0;
    rst = 1'b1; #1;
    chk("rst_mid_ready", fetch_ready, 0);
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", dec_valid, 0);
    send_one(32'h00A00113, 32'h500);
    chk("rst_mid_instr", dec_instr, 32'h00A00113);
    chk("rst_mid_pc", dec_pc, 32'h500);
    chk("rst_mid_illegal", dec_illegal, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
